// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration handshake bundle: drive requests and controls in,
// registered grant/select/conflict status out.
interface bus_source_arbiter_if #(
  parameter int N_SRC = 25,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
);
  logic [N_SRC-1:0] req;
  logic             mode;
  logic             lock;
  logic             clr_cnt;
  logic [N_SRC-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output req, mode, lock, clr_cnt,
    input  grant, sel, valid, conflict, conflict_cnt
  );

  modport slave (
    input  req, mode, lock, clr_cnt,
    output grant, sel, valid, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// Registered datapath bus-source arbiter: fixed-priority or round-robin winner,
// grant lock for multi-cycle transfers, multi-driver conflict flag and counter.
module bus_source_arbiter #(
  parameter int N_SRC       = 25,
  parameter int SEL_W       = 5,
  parameter int DEFAULT_SEL = 0,
  parameter int CNT_W       = 8
) (
  input logic                clock,
  input logic                clear,
  bus_source_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

  state_t           state;
  logic [N_SRC-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             conflict_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] rr_ptr;

  logic [SEL_W-1:0] fp_win, rr_win, rr_idx, win;
  logic             multi;

  // Highest set index wins; later iterations overwrite earlier ones.
  always_comb begin
    fp_win = '0;
    for (int i = 0; i < N_SRC; i++)
      if (bus.req[i]) fp_win = SEL_W'(i);
  end

  // Walk the ring downward so the candidate closest after rr_ptr is written last.
  always_comb begin
    rr_win = '0;
    rr_idx = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      rr_idx = SEL_W'((int'(rr_ptr) + k) % N_SRC);
      if (bus.req[rr_idx]) rr_win = rr_idx;
    end
  end

  assign win   = bus.mode ? rr_win : fp_win;
  assign multi = ($countones(bus.req) >= 2);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      grant_q    <= '0;
      sel_q      <= SEL_W'(DEFAULT_SEL);
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      rr_ptr     <= SEL_W'(N_SRC - 1);
    end else begin
      conflict_q <= multi;
      if (bus.clr_cnt)
        cnt_q <= '0;
      else if (multi && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;

      // Lock only has something to hold once a grant exists.
      if (state != IDLE && bus.lock) begin
        state <= LOCKED;
      end else if (|bus.req) begin
        state   <= GRANT;
        grant_q <= ONE_HOT0 << win;
        sel_q   <= win;
        valid_q <= 1'b1;
        rr_ptr  <= win;
      end else begin
        state   <= IDLE;
        grant_q <= '0;
        sel_q   <= SEL_W'(DEFAULT_SEL);
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.sel          = sel_q;
  assign bus.valid        = valid_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: expectations queued at drive time,
// popped and compared one cycle later.
module tb_bus_source_arbiter;
  localparam int N  = 25;
  localparam int SW = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bus_source_arbiter_if #(.N_SRC(N), .SEL_W(SW), .CNT_W(CW)) bus ();

  bus_source_arbiter #(.N_SRC(N), .SEL_W(SW), .DEFAULT_SEL(0), .CNT_W(CW)) dut (
    .clock (clk),
    .clear (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          valid;
    logic          conflict;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ecnt    = 0;

  function automatic exp_t mk(input int idx, input int cnt, input logic cf);
    exp_t e;
    logic [N-1:0] one;
    one        = 1;
    e.grant    = (idx < 0) ? '0 : (one << idx);
    e.sel      = (idx < 0) ? '0 : SW'(idx);
    e.valid    = (idx >= 0);
    e.conflict = cf;
    e.cnt      = CW'(cnt);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.grant    = bus.grant;
    o.sel      = bus.sel;
    o.valid    = bus.valid;
    o.conflict = bus.conflict;
    o.cnt      = bus.conflict_cnt;
    return o;
  endfunction

  function automatic int hi_idx(input logic [N-1:0] r);
    int h = -1;
    for (int i = 0; i < N; i++) if (r[i]) h = i;
    return h;
  endfunction

  function automatic logic [N-1:0] bits(input int a, input int b, input int c);
    logic [N-1:0] r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  // Apply one cycle of stimulus and queue what must appear after the edge.
  task automatic drive(input logic [N-1:0] r, input logic l, input logic c, input int idx);
    logic cf;
    bus.req     = r;
    bus.lock    = l;
    bus.clr_cnt = c;
    cf   = ($countones(r) >= 2);
    ecnt = c ? 0 : ((cf && ecnt < 255) ? ecnt + 1 : ecnt);
    sbq.push_back(mk(idx, ecnt, cf));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    ecnt = 0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    bus.req = '1; bus.mode = 1'b0; bus.lock = 1'b0; bus.clr_cnt = 1'b0;
    rst_n = 1'b0;
    ecnt  = 0;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk(-1, 0, 1'b0));
      @(posedge clk); #1;
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want %h", i, o, e);
      end
    end
    bus.req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [N-1:0] rq[7];
    int           ix[7];
    exp_t e, o;
    bus.mode = 1'b0;
    rq[0] = bits(3, 17, 24); ix[0] = 24;
    rq[1] = '0;              ix[1] = -1;
    rq[2] = bits(0, 1, -1);  ix[2] = 1;
    rq[3] = bits(24, -1, -1);ix[3] = 24;
    rq[4] = '1;              ix[4] = 24;
    rq[5] = bits(0, -1, -1); ix[5] = 0;
    rq[6] = '0;              ix[6] = -1;
    for (int i = 0; i < 7; i++) begin
      drive(rq[i], 1'b0, 1'b0, ix[i]);
      if (sbq.size() == 0) begin n_tests++; n_fail++; $display("FAIL fixed[%0d]: scoreboard empty", i); continue; end
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fixed[%0d]: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rq[10];
    int           ix[10];
    exp_t e, o;
    pulse_reset();
    bus.mode = 1'b1;
    for (int i = 0; i < 5; i++) rq[i] = bits(2, 5, 9);
    ix[0] = 2; ix[1] = 5; ix[2] = 9; ix[3] = 2; ix[4] = 5;
    rq[5] = bits(0, 24, -1); ix[5] = 24;
    rq[6] = bits(0, 24, -1); ix[6] = 0;
    rq[7] = '0;              ix[7] = -1;
    rq[8] = bits(2, 5, 9);   ix[8] = 2;
    rq[9] = '0;              ix[9] = -1;
    for (int i = 0; i < 10; i++) begin
      drive(rq[i], 1'b0, 1'b0, ix[i]);
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rr[%0d]: got %h want %h", i, o, e);
      end
    end
    bus.mode = 1'b0;
  endtask

  task automatic test_lock();
    logic [N-1:0] rq[11];
    logic         lk[11];
    int           ix[11];
    exp_t e, o;
    bus.mode = 1'b0;
    rq[0]  = bits(7, -1, -1);  lk[0]  = 0; ix[0]  = 7;
    rq[1]  = bits(20, -1, -1); lk[1]  = 1; ix[1]  = 7;
    rq[2]  = bits(20, -1, -1); lk[2]  = 1; ix[2]  = 7;
    rq[3]  = bits(20, 21, -1); lk[3]  = 1; ix[3]  = 7;
    rq[4]  = bits(20, -1, -1); lk[4]  = 0; ix[4]  = 20;
    rq[5]  = '0;               lk[5]  = 0; ix[5]  = -1;
    rq[6]  = '0;               lk[6]  = 1; ix[6]  = -1;
    rq[7]  = bits(4, -1, -1);  lk[7]  = 1; ix[7]  = 4;
    rq[8]  = bits(9, -1, -1);  lk[8]  = 1; ix[8]  = 4;
    rq[9]  = '0;               lk[9]  = 1; ix[9]  = 4;
    rq[10] = '0;               lk[10] = 0; ix[10] = -1;
    for (int i = 0; i < 11; i++) begin
      drive(rq[i], lk[i], 1'b0, ix[i]);
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lock[%0d]: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_counter();
    exp_t e, o;
    bus.mode = 1'b0;
    for (int i = 0; i < 303; i++) begin
      drive(bits(0, 1, -1), 1'b0, (i == 300), 1);
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL counter[%0d]: got %h want %h", i, o, e);
      end
    end
    drive('0, 1'b0, 1'b0, -1);
    e = sbq.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL counter_idle: got %h want %h", o, e);
    end
  endtask

  task automatic test_idle_async();
    logic [N-1:0] rq[3];
    logic         lk[3];
    int           ix[3];
    exp_t e, o;
    rq[0] = '0;               lk[0] = 0; ix[0] = -1;
    rq[1] = bits(12, -1, -1); lk[1] = 0; ix[1] = 12;
    rq[2] = bits(12, -1, -1); lk[2] = 1; ix[2] = 12;
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], lk[i], 1'b0, ix[i]);
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_lock[%0d]: got %h want %h", i, o, e);
      end
    end
    // Now LOCKED: pulse reset between edges and look before any edge arrives.
    #2 rst_n = 1'b0;
    ecnt = 0;
    #1;
    e = mk(-1, 0, 1'b0); o = obs(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", o, e);
    end
    bus.req = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rq[0] = '0;               lk[0] = 1; ix[0] = -1;
    rq[1] = bits(12, -1, -1); lk[1] = 1; ix[1] = 12;
    rq[2] = '0;               lk[2] = 0; ix[2] = -1;
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], lk[i], 1'b0, ix[i]);
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] r;
    exp_t e, o;
    bus.mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0:       r = '0;
        1:       r = bits(int'($urandom_range(0, N-1)), -1, -1);
        default: r = N'($urandom);
      endcase
      drive(r, 1'b0, 1'b0, hi_idx(r));
      e = sbq.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] req=%h: got %h want %h", i, r, o, e);
      end
    end
  endtask

  initial begin
    bus.req = '1; bus.mode = 1'b0; bus.lock = 1'b0; bus.clr_cnt = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_lock();
    test_counter();
    test_idle_async();
    test_back_to_back();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
